// File: rtl/definitions_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package definitions_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } uart_arb_state_t;

    localparam int UART_BYTE_W = 8;

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: returns the first set request bit strictly after ptr, with wrap-around.
module rr_select #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the farthest offset down so the nearest request above ptr is assigned last and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                found = 1'b1;
                idx   = IDX_W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-locked round-robin arbiter feeding one UART TX FIFO from NUM_REQ byte-stream requesters.
// Optional idle-frame timeout is enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import definitions_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = UART_BYTE_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        tx_full,
    output logic                        wr_uart,
    output logic [DATA_W-1:0]           in,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    uart_arb_state_t                  state, state_nxt;
    logic [IDX_W-1:0]                 rr_ptr, rr_ptr_nxt, grant_nxt;
    logic [NUM_REQ-1:0][DATA_W-1:0]   data_a;
    logic                             pick_found;
    logic [IDX_W-1:0]                 pick_idx;
    logic                             xfer, gvalid, accept, to_hit;

    assign data_a  = req_data;
    assign xfer    = (state == XFER);
    assign gvalid  = req_valid[grant_id];
    assign accept  = xfer & gvalid & ~tx_full;
    assign wr_uart = accept;
    assign in      = xfer ? data_a[grant_id] : '0;
    assign busy    = xfer;

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[grant_id] = ~tx_full;
    end

    rr_select #(.N(NUM_REQ), .IDX_W(IDX_W)) u_sel (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive silent cycle of a locked frame.
    assign to_hit      = xfer & ~gvalid & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = to_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        to_cnt <= '0;
        else if (!xfer || accept || to_hit) to_cnt <= '0;
        else if (!gvalid)                 to_cnt <= to_cnt + TO_W'(1);
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign to_hit         = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant_id;
        case (state)
            IDLE: if (pick_found) begin
                state_nxt = XFER;
                grant_nxt = pick_idx;
            end
            XFER: if ((accept & req_last[grant_id]) | to_hit) begin
                state_nxt  = IDLE;
                rr_ptr_nxt = grant_id;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= IDX_W'(NUM_REQ - 1);
            grant_id <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant_id <= grant_nxt;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing the `uart_Split` transmit path among `NUM_REQ` on-chip requesters. Each requester offers framed byte streams over valid/ready. The arbiter locks the UART to one requester for a whole frame, which ends on a `last` beat. It drives `wr_uart`/`in` into the TX FIFO and back-pressures on `tx_full`. It sits between the processing blocks (status, debug, result dump) and the single UART instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `DATA_W`, 8: byte width; fixed to 8 to match UART
- `TIMEOUT_CYCLES`, 1024: idle cycles within a locked frame before forced release; used only with the macro
- `clk`  in  1: system clock
- `reset`  in  1: asynchronous, active-high reset
- `req_valid`  in  NUM_REQ: requester i has a byte on its data slice
- `req_data`  in  NUM_REQ*8: requester i data at bits [8i+7:8i]
- `req_last`  in  NUM_REQ: byte on slice i is the final byte of its frame
- `req_ready`  out  NUM_REQ: byte on slice i accepted this cycle when valid&ready
- `tx_full`  in  1: UART TX FIFO full
- `wr_uart`  out  1: single-cycle write strobe into UART TX FIFO
- `in`  out  8: byte to UART, valid while `wr_uart`=1
- `grant_id`  out  $clog2(NUM_REQ): currently locked requester
- `busy`  out  1: a frame is locked
- `timeout_err`  out  1: one-cycle pulse on forced release

## Operation
- States: IDLE, XFER.
- IDLE: if any `req_valid`, pick the first set bit searching from `rr_ptr+1` upward with wrap-around. Register it into `grant_id`, then go to XFER. No bytes are accepted in IDLE.
- XFER: `req_ready[grant_id] = !tx_full`; all other `req_ready` are 0. `wr_uart = req_valid[grant_id] & !tx_full`; `in = req_data` slice of `grant_id`. Both are combinational from state and inputs.
- A beat accepted with `req_last[grant_id]=1` sets `rr_ptr <= grant_id` and returns to IDLE.
- `busy` = (state==XFER). A requester may drop valid mid-frame; the lock is held.
- A single-byte frame (valid & last on the first beat) is legal.
- Simultaneous requests: the lowest index above `rr_ptr` wins. A requester is never granted twice while another is waiting.

## Timing
- Reset values: state IDLE, `rr_ptr` = NUM_REQ-1 (requester 0 is served first), `grant_id` 0, `busy` 0, `wr_uart` 0, `in` 0 (data mux gated by state), `req_ready` all 0, `timeout_err` 0, timeout counter 0.
- Grant latency: valid seen at cycle N gives XFER at N+1; first `wr_uart` earliest at N+1.
- Throughput: one byte per cycle while `!tx_full`.
- Frame-to-frame gap: minimum one IDLE cycle after each `last` beat.
- `tx_full` rising stalls the transfer in the same cycle with no data loss. The requester holds its data until ready.
- Valid withdrawn in IDLE before the grant registers: the grant still occurs, and XFER waits for valid.
- Reset asserted mid-frame: everything returns to reset values at once. The partial frame is abandoned and the UART FIFO is not flushed by this block.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter increments each XFER cycle with `req_valid[grant_id]=0` and clears on any accepted beat.
  - On reaching TIMEOUT_CYCLES: pulse `timeout_err` for 1 cycle, set `rr_ptr <= grant_id`, return to IDLE.
- Not defined: no counter is instantiated, `timeout_err` is tied 0, and the lock is held until `last`.

## Structure
- `definitions_pkg`:
  - `uart_arb_state_t` enum {IDLE, XFER}
  - constant `UART_BYTE_W = 8`
- Sub-module `rr_select`: combinational one-hot/index pick from a request vector and a pointer. The arbiter instantiates it once.

## Test plan
- Single requester 0 sends frame 0x41,0x42,0x43(last) with `tx_full`=0 -> `wr_uart` on 3 consecutive cycles starting 1 cycle after valid, `in`=41,42,43, then `busy`=0.
- Requesters 0,1,2 all valid at once with 2-byte frames -> service order 0,1,2, then 0 again on re-request; `grant_id` sequence 0,1,2; no interleaving of bytes.
- `tx_full` held 1 for 5 cycles mid-frame from requester 3 -> `req_ready`/`wr_uart` stay 0 for those cycles; byte 0x55 is written on the first cycle after release, none lost or duplicated.
- Requester 1 drops valid mid-frame while requester 2 is valid -> lock held on 1, `req_ready[2]`=0 until requester 1 sends last.
- With `UART_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=16, requester 0 goes silent after 1 byte -> `timeout_err` pulses on idle cycle 16 and requester 1 is granted next cycle; without the macro, no pulse and the lock persists.
- Assert `reset` mid-frame after 2 of 4 bytes -> all outputs at reset values immediately; the next request from requester 2 with requester 0 also valid grants 0 first.
